// File: rtl/cve2_obi_mem_responder.sv
// Memory-side request/grant/response responder: word SRAM, byte-masked writes, in-order response
// FIFO with minimum latency. Define CVE2_OBI_RESP_RANDOM_STALL_EN to add LFSR-driven grant stalls.
module cve2_obi_mem_responder #(
    parameter int unsigned MemWords       = 4096,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned RespLatency    = 1,
    parameter logic [31:0] ErrAddrBase    = 32'hFFFF_F000,
    parameter logic [31:0] ErrAddrMask    = 32'hFFFF_F000,
    parameter logic [15:0] LfsrSeed       = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        gnt_stall_i,
    input  logic        resp_stall_i
);

    localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [2:0]      EligibleAge = 3'(RespLatency - 1);
    localparam logic [CntW-1:0] CntMax      = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast     = PtrW'(MaxOutstanding - 1);

    logic [31:0]               mem [MemWords];
    logic                      ready_q;
    logic [PtrW-1:0]           wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [CntW-1:0]           count_q, count_d;
    logic [MaxOutstanding-1:0] valid_q, valid_d;
    logic [31:0]               entryData_q [MaxOutstanding];
    logic [MaxOutstanding-1:0] entryErr_q;
    logic [2:0]                entryAge_q [MaxOutstanding];

    logic            lfsrStall;
    logic            push;
    logic            pop;
    logic            accessErr;
    logic            headEligible;
    logic [IdxW-1:0] wordIdx;
    logic [31:0]     pushData;
    logic [1:0]      unusedAddrLsb;

    assign unusedAddrLsb = addr_i[1:0];

`ifdef CVE2_OBI_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11; stalls grants about a quarter of the time
    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign lfsrStall = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic [15:0] unusedSeed;

    assign unusedSeed = LfsrSeed;
    assign lfsrStall  = 1'b0;
`endif

    // FIFO space is judged on the registered count, so a pop never frees a slot in the same cycle
    assign gnt_o = req_i & ready_q & ~gnt_stall_i & (count_q < CntMax) & ~lfsrStall;
    assign push  = gnt_o;

    assign wordIdx   = addr_i[2 +: IdxW];
    assign accessErr = (32'(addr_i[31:2]) >= MemWords) | ((addr_i & ErrAddrMask) == ErrAddrBase);
    assign pushData  = (we_i | accessErr) ? 32'h0 : mem[wordIdx];

    always_ff @(posedge clk_i) begin
        if (push && we_i && !accessErr) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem[wordIdx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign headEligible = valid_q[rdPtr_q] & (entryAge_q[rdPtr_q] >= EligibleAge);
    assign rvalid_o     = headEligible & ~resp_stall_i;
    assign pop          = rvalid_o;
    assign rdata_o      = rvalid_o ? entryData_q[rdPtr_q] : 32'h0;
    assign err_o        = rvalid_o & entryErr_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        valid_d = valid_q;
        if (push) begin
            valid_d[wrPtr_q] = 1'b1;
            wrPtr_d          = (wrPtr_q == PtrLast) ? '0 : wrPtr_q + 1'b1;
        end
        if (pop) begin
            valid_d[rdPtr_q] = 1'b0;
            rdPtr_d          = (rdPtr_q == PtrLast) ? '0 : rdPtr_q + 1'b1;
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= 1'b0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            ready_q <= 1'b1;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Pushed entries start at age 0; live entries age every cycle and saturate at 7
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                entryData_q[i] <= '0;
                entryAge_q[i]  <= '0;
            end
            entryErr_q <= '0;
        end else begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                if (push && (wrPtr_q == PtrW'(i))) begin
                    entryData_q[i] <= pushData;
                    entryErr_q[i]  <= accessErr;
                    entryAge_q[i]  <= 3'd0;
                end else if (valid_q[i] && (entryAge_q[i] != 3'd7)) begin
                    entryAge_q[i] <= entryAge_q[i] + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cve2_obi_mem_responder.sv
// Self-checking bench for cve2_obi_mem_responder: transaction-level model (memory array plus a
// queue of timed responses) compared every cycle, directed scenarios, then randomized traffic.
`timescale 1ns/1ps
module tb_cve2_obi_mem_responder;

    localparam int MaxOut = 2;
    localparam int Lat    = 3;

    logic        clk_i;
    logic        rst_ni;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        gnt_stall_i;
    logic        resp_stall_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } resp_t;

    resp_t       respQ[$];
    logic [31:0] memM [4096];
    logic        readyM = 1'b0;
    int          gntLog[$];
    int          rvLog[$];
    int          rvErrLog[$];
    logic [31:0] rvDataLog[$];
    logic [31:0] initData [16];
    logic [31:0] aliasData;

    cve2_obi_mem_responder #(
        .MaxOutstanding(MaxOut),
        .RespLatency   (Lat)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .gnt_stall_i (gnt_stall_i),
        .resp_stall_i(resp_stall_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int atI(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [31:0] atD(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
    endfunction

    // Any byte address at or above 16 KiB lies outside the 4096-word array; the top 4 KiB is the error window
    function automatic logic isErr(input logic [31:0] a);
        return (a >= 32'h0000_4000) || ((a & 32'hFFFF_F000) == 32'hFFFF_F000);
    endfunction

    // Model: each grant queues a response due Lat cycles later; responses leave in order, one per cycle
    always @(negedge clk_i) begin : compare
        logic        expGnt;
        logic        expRv;
        logic        expErr;
        logic [31:0] expData;
        resp_t       r;
        int          idx;
        expGnt  = 1'b0;
        expRv   = 1'b0;
        expErr  = 1'b0;
        expData = 32'h0;
        if (!rst_ni) begin
            respQ.delete();
            readyM = 1'b0;
        end else begin
            expGnt = req_i && readyM && !gnt_stall_i && (respQ.size() < MaxOut);
            if (respQ.size() > 0 && cyc >= respQ[0].due && !resp_stall_i) begin
                expRv   = 1'b1;
                expData = respQ[0].data;
                expErr  = respQ[0].err;
            end
        end
        checkOutput("gnt", 32'(gnt_o), 32'(expGnt));
        checkOutput("rvalid", 32'(rvalid_o), 32'(expRv));
        checkOutput("rdata", rdata_o, expData);
        checkOutput("err", 32'(err_o), 32'(expErr));
        if (gnt_o) gntLog.push_back(cyc);
        if (rvalid_o) begin
            rvLog.push_back(cyc);
            rvDataLog.push_back(rdata_o);
            rvErrLog.push_back(int'(err_o));
        end
        if (rst_ni) begin
            if (expRv) void'(respQ.pop_front());
            if (expGnt) begin
                r.err  = isErr(addr_i);
                r.due  = cyc + Lat;
                r.data = 32'h0;
                idx    = int'(addr_i[13:2]);
                if (!r.err && we_i) begin
                    for (int b = 0; b < 4; b++) begin
                        if (be_i[b]) memM[idx][8*b +: 8] = wdata_i[8*b +: 8];
                    end
                end else if (!r.err) begin
                    r.data = memM[idx];
                end
                respQ.push_back(r);
            end
            readyM = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clearLogs();
        gntLog.delete();
        rvLog.delete();
        rvDataLog.delete();
        rvErrLog.delete();
    endtask

    // Holds a single request until it is granted (bounded), then drops req_i after the grant edge
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata, output int gCyc);
        bit granted;
        granted = 1'b0;
        gCyc    = -1;
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        be_i    = be;
        wdata_i = wdata;
        for (int k = 0; k < 50 && !granted; k++) begin
            @(negedge clk_i);
            if (gnt_o) begin
                granted = 1'b1;
                gCyc    = cyc;
            end
            step();
        end
        req_i = 1'b0;
        if (!granted) begin
            checks++;
            errors++;
            $display("[TB] FAIL grantTimeout: got no grant, expected one within 50 cycles (addr %h)", addr);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g;
        int g1;
        int r;
        int c0;
        int d;
        bit granted;

        rst_ni       = 1'b0;
        req_i        = 1'b1;
        we_i         = 1'b1;
        addr_i       = 32'h0;
        be_i         = 4'hF;
        wdata_i      = 32'h1234_5678;
        gnt_stall_i  = 1'b0;
        resp_stall_i = 1'b0;

        // Reset release with a request held high throughout
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checkOutput("resetGnt", 32'(gnt_o), 32'h0);
            checkOutput("resetRvalid", 32'(rvalid_o), 32'h0);
            checkOutput("resetRdata", rdata_o, 32'h0);
            checkOutput("resetErr", 32'(err_o), 32'h0);
        end
        step();
        clearLogs();
        rst_ni = 1'b1;
        r      = cyc;
        granted = 1'b0;
        for (int k = 0; k < 10 && !granted; k++) begin
            @(negedge clk_i);
            granted = gnt_o;
            step();
        end
        req_i = 1'b0;
        checkOutput("firstGrantCycle", 32'(atI(gntLog, 0)), 32'(r + 1));
        waitCycles(6);

        // Known contents for the region used by directed and random reads
        for (int i = 0; i < 16; i++) begin
            initData[i] = $urandom;
            applyStimulus(1'b1, 32'(4 * i), 4'hF, initData[i], g);
        end
        aliasData = $urandom;
        applyStimulus(1'b1, 32'h0000_3004, 4'hF, 32'h0BAD_CAFE, g);
        applyStimulus(1'b1, 32'h0000_3008, 4'hF, aliasData, g);
        waitCycles(6);

        // Partial write over a zeroed word, then read it back
        applyStimulus(1'b1, 32'h10, 4'hF, 32'h0, g);
        applyStimulus(1'b1, 32'h10, 4'b0101, 32'hDEAD_BEEF, g);
        waitCycles(6);
        clearLogs();
        applyStimulus(1'b0, 32'h10, 4'h0, 32'h0, g);
        waitCycles(6);
        checkOutput("wrRdLatency", 32'(atI(rvLog, 0)), 32'(g + Lat));
        checkOutput("wrRdData", atD(rvDataLog, 0), 32'h00AD_00EF);
        checkOutput("wrRdErr", 32'(atI(rvErrLog, 0)), 32'h0);

        // Back-to-back reads with req_i held: throughput bounded by two in flight
        clearLogs();
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h4;
        c0     = cyc;
        waitCycles(10);
        req_i = 1'b0;
        waitCycles(8);
        checkOutput("btbGnt0", 32'(atI(gntLog, 0)), 32'(c0));
        checkOutput("btbGnt1", 32'(atI(gntLog, 1)), 32'(c0 + 1));
        checkOutput("btbGnt2", 32'(atI(gntLog, 2)), 32'(c0 + 4));
        checkOutput("btbRv0", 32'(atI(rvLog, 0)), 32'(c0 + 3));
        checkOutput("btbRv1", 32'(atI(rvLog, 1)), 32'(c0 + 4));
        checkOutput("btbData", atD(rvDataLog, 0), initData[1]);

        // Error window and out-of-range accesses; the write must not reach the aliased word
        clearLogs();
        applyStimulus(1'b0, 32'hFFFF_F004, 4'h0, 32'h0, g);
        applyStimulus(1'b1, 32'hFFFF_F008, 4'hF, 32'hCAFE_F00D, g);
        applyStimulus(1'b0, 32'h0000_4000, 4'h0, 32'h0, g);
        waitCycles(8);
        for (int i = 0; i < 3; i++) begin
            checkOutput("errFlag", 32'(atI(rvErrLog, i)), 32'h1);
            checkOutput("errData", atD(rvDataLog, i), 32'h0);
        end
        clearLogs();
        applyStimulus(1'b0, 32'h0000_3008, 4'h0, 32'h0, g);
        waitCycles(6);
        checkOutput("aliasUnchanged", atD(rvDataLog, 0), aliasData);

        // Response stall with the FIFO full
        clearLogs();
        resp_stall_i = 1'b1;
        applyStimulus(1'b0, 32'h20, 4'h0, 32'h0, g1);
        applyStimulus(1'b0, 32'h24, 4'h0, 32'h0, g);
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h28;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            checkOutput("fullNoGnt", 32'(gnt_o), 32'h0);
            checkOutput("stallNoRvalid", 32'(rvalid_o), 32'h0);
            step();
        end
        resp_stall_i = 1'b0;
        d = cyc;
        granted = 1'b0;
        for (int k = 0; k < 20 && !granted; k++) begin
            @(negedge clk_i);
            granted = gnt_o;
            step();
        end
        req_i = 1'b0;
        waitCycles(8);
        checkOutput("stallRv0", 32'(atI(rvLog, 0)), 32'(d));
        checkOutput("stallRv1", 32'(atI(rvLog, 1)), 32'(d + 1));
        checkOutput("stallData0", atD(rvDataLog, 0), initData[8]);
        checkOutput("stallData1", atD(rvDataLog, 1), initData[9]);
        checkOutput("stallResume", 32'(atI(gntLog, 2)), 32'(d + 1));

        // Reset while two reads are pending: they vanish, memory survives
        applyStimulus(1'b1, 32'h30, 4'hF, 32'h5A5A_1234, g);
        waitCycles(6);
        clearLogs();
        applyStimulus(1'b0, 32'h30, 4'h0, 32'h0, g);
        applyStimulus(1'b0, 32'h34, 4'h0, 32'h0, g);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        waitCycles(10);
        checkOutput("flushedResponses", 32'(rvLog.size()), 32'h0);
        applyStimulus(1'b0, 32'h30, 4'h0, 32'h0, g);
        waitCycles(6);
        checkOutput("dataAfterReset", atD(rvDataLog, 0), 32'h5A5A_1234);

        // Randomized traffic with stalls, partial writes and error addresses
        for (int n = 0; n < 500; n++) begin
            req_i = ($urandom_range(0, 9) < 7);
            we_i  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       addr_i = 32'hFFFF_F000 | 32'($urandom_range(0, 32'hFFF));
                1:       addr_i = 32'h0000_4000 + 32'($urandom_range(0, 32'hFF));
                default: addr_i = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            endcase
            be_i         = 4'($urandom);
            wdata_i      = $urandom;
            gnt_stall_i  = ($urandom_range(0, 4) == 0);
            resp_stall_i = ($urandom_range(0, 4) == 0);
            step();
        end
        req_i        = 1'b0;
        gnt_stall_i  = 1'b0;
        resp_stall_i = 1'b0;
        waitCycles(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
